uart_mmio: RTL

UART_MMIO -- requirements
Module: uart_mmio

---
 rtl/uart_mmio.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART with a TX FIFO (DATA at 0x002, STATUS at 0x004).
// The receiver is compiled in only when UART_MMIO_RX_EN is defined.
module uart_mmio #(
  parameter int unsigned BAUD_DIV   = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  mem_addr,
  input  logic        mem_wr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic data_sel, status_sel, data_rd, status_rd;
  logic push_req, push, pop, drop_evt;

  assign data_sel   = (mem_addr == 10'h002);
  assign status_sel = (mem_addr == 10'h004);
  assign data_rd    = !mem_wr && data_sel;
  assign status_rd  = !mem_wr && status_sel;
  assign push_req   = mem_wr && data_sel;

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty, fifo_full;
  logic [7:0]    fifo_head;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL);
  assign push       = push_req && !fifo_full;
  assign drop_evt   = push_req && fifo_full;
  // A write into an empty FIFO is forwarded straight to the transmitter.
  assign fifo_head  = fifo_empty ? wr_data[7:0] : fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wr_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + (AW+1)'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - (AW+1)'(1);
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          tx_out, tx_out_n, tx_avail, tx_idle;

  assign tx_avail = !fifo_empty || push;
  assign tx_idle  = fifo_empty && (tx_state == TX_IDLE);
  assign uart_tx  = tx_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_out   <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_out   <= tx_out_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + CW'(1);
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_out_n   = tx_out;
    pop        = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        tx_out_n = 1'b1;
        if (tx_avail) begin
          pop        = 1'b1;
          tx_shift_n = fifo_head;
          tx_out_n   = 1'b0;
          tx_state_n = TX_START;
        end
      end
      TX_START: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
        tx_out_n   = tx_shift[0];
        tx_state_n = TX_DATA;
      end
      TX_DATA: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n = '0;
        if (tx_bit == 3'd7) begin
          tx_out_n   = 1'b1;
          tx_state_n = TX_STOP;
        end else begin
          tx_bit_n   = tx_bit + 3'd1;
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_out_n   = tx_shift[1];
        end
      end
      TX_STOP: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n = '0;
        if (tx_avail) begin
          pop        = 1'b1;
          tx_shift_n = fifo_head;
          tx_out_n   = 1'b0;
          tx_state_n = TX_START;
        end else begin
          tx_state_n = TX_IDLE;
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        tx_cnt_n   = '0;
        tx_out_n   = 1'b1;
      end
    endcase
  end

  // ---------------- RX ----------------
  logic       rx_valid, rx_overrun, rx_ferr;
  logic [7:0] rx_data;

`ifdef UART_MMIO_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam logic [CW-1:0] RX_MID = CW'(BAUD_DIV / 2 - 1);

  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_meta, rx_sync, rx_prev, rx_done, rx_bad;
  logic          unused_inputs;

  assign unused_inputs = ^wr_data[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_ferr    <= 1'b0;
      rx_data    <= '0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      // A byte landing on the same edge as a DATA read replaces the one being read.
      if (rx_done)      rx_valid <= 1'b1;
      else if (data_rd) rx_valid <= 1'b0;
      if (rx_done && (!rx_valid || data_rd)) rx_data <= rx_shift;
      if (rx_done && rx_valid && !data_rd) rx_overrun <= 1'b1;
      else if (status_rd)                  rx_overrun <= 1'b0;
      if (rx_bad)         rx_ferr <= 1'b1;
      else if (status_rd) rx_ferr <= 1'b0;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + CW'(1);
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_sync) rx_state_n = RX_START;
      end
      RX_START: if (rx_cnt == RX_MID) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n   = '0;
        rx_shift_n = {rx_sync, rx_shift[7:1]};
        rx_bit_n   = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
      end
      RX_STOP: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n   = '0;
        rx_state_n = RX_IDLE;
        rx_done    = rx_sync;
        rx_bad     = !rx_sync;
      end
      default: begin
        rx_state_n = RX_IDLE;
        rx_cnt_n   = '0;
      end
    endcase
  end
`else
  logic unused_inputs;

  assign unused_inputs = ^{wr_data[15:8], uart_rx};
  assign rx_valid      = 1'b0;
  assign rx_overrun    = 1'b0;
  assign rx_ferr       = 1'b0;
  assign rx_data       = '0;
`endif

  // ---------------- flags and read port ----------------
  logic        tx_drop;
  logic [15:0] status_word, data_word;

  assign status_word = {10'b0, rx_ferr, tx_drop, rx_overrun, rx_valid, tx_idle, fifo_full};
  assign data_word   = rx_valid ? {8'h00, rx_data} : 16'h0000;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_drop <= 1'b0;
      rd_data <= '0;
    end else begin
      if (drop_evt)       tx_drop <= 1'b1;
      else if (status_rd) tx_drop <= 1'b0;
      if (!mem_wr) begin
        if (data_sel)        rd_data <= data_word;
        else if (status_sel) rd_data <= status_word;
        else                 rd_data <= '0;
      end
    end
  end

endmodule
